// File: rtl/core_bus.sv
// rtl/core_bus.sv - 8086 byte-bus decoder/read mux with optional tick timer (CORE_BUS_TIMER_EN)
// Regions: RAM, text VRAM, boot ROM, timer; read data returns one cycle after the address.
module core_bus #(
  parameter int RAM_BITS = 16,
  parameter int PRESCALE = 25000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [19:0]         cpu_address,
  input  logic [7:0]          cpu_out,
  input  logic                cpu_we,
  output logic [7:0]          cpu_in,
  output logic [RAM_BITS-1:0] ram_a,
  input  logic [7:0]          ram_i,
  output logic [7:0]          ram_o,
  output logic                ram_w,
  output logic [11:0]         vid_a,
  input  logic [7:0]          vid_i,
  output logic [7:0]          vid_o,
  output logic                vid_w,
  output logic [15:0]         rom_a,
  input  logic [7:0]          rom_i
);

  localparam logic [2:0] R_NONE = 3'd0;
  localparam logic [2:0] R_RAM  = 3'd1;
  localparam logic [2:0] R_VID  = 3'd2;
  localparam logic [2:0] R_ROM  = 3'd3;
  localparam logic [2:0] R_TMR  = 3'd4;

  logic [2:0] region;
  logic [2:0] sel;

  always_comb begin
    region = R_NONE;
    if ((cpu_address >> RAM_BITS) == 20'd0)
      region = R_RAM;
    else if (cpu_address[19:12] == 8'hB8)
      region = R_VID;
    else if (cpu_address[19:16] == 4'hF)
      region = R_ROM;
`ifdef CORE_BUS_TIMER_EN
    else if (cpu_address[19:3] == 17'h1C000)
      region = R_TMR;
`endif
  end

  assign ram_a = cpu_address[RAM_BITS-1:0];
  assign vid_a = cpu_address[11:0];
  assign rom_a = cpu_address[15:0];
  assign ram_o = cpu_out;
  assign vid_o = cpu_out;
  assign ram_w = cpu_we & (region == R_RAM);
  assign vid_w = cpu_we & (region == R_VID);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sel <= R_NONE;
    else          sel <= region;
  end

`ifdef CORE_BUS_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [15:0]   cnt, cmp, cnt_inc;
  logic [7:0]    shadow, tmr_q, tmr_rdata;
  logic [PW-1:0] presc;
  logic          en, match;
  logic          tmr_sel, tmr_wr, tmr_rd, cnt_wr, tick;
  logic [2:0]    off;

  assign tmr_sel = (region == R_TMR);
  assign off     = cpu_address[2:0];
  assign tmr_wr  = tmr_sel & cpu_we;
  assign tmr_rd  = tmr_sel & ~cpu_we;
  assign cnt_wr  = tmr_wr & (off[2:1] == 2'b00);
  assign tick    = en & (presc == PLAST);
  assign cnt_inc = cnt + 16'd1;

  always_comb begin
    tmr_rdata = 8'h00;
    case (off)
      3'd0:    tmr_rdata = cnt[7:0];
      3'd1:    tmr_rdata = shadow;
      3'd2:    tmr_rdata = cmp[7:0];
      3'd3:    tmr_rdata = cmp[15:8];
      3'd4:    tmr_rdata = {en, 6'b0, match};
      default: tmr_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 16'h0000;
      cmp    <= 16'hFFFF;
      shadow <= 8'h00;
      tmr_q  <= 8'h00;
      presc  <= '0;
      en     <= 1'b0;
      match  <= 1'b0;
    end else begin
      if (tmr_sel) tmr_q <= tmr_rdata;
      // Low-byte read snapshots the high byte so a following CNTH read is coherent.
      if (tmr_rd && off == 3'd0) shadow <= cnt[15:8];

      if (cnt_wr)  presc <= '0;
      else if (en) presc <= tick ? '0 : presc + PW'(1);

      if (cnt_wr) begin
        if (off[0]) cnt[15:8] <= cpu_out;
        else        cnt[7:0]  <= cpu_out;
      end else if (tick) begin
        cnt <= cnt_inc;
      end

      if (tmr_wr && off == 3'd2) cmp[7:0]  <= cpu_out;
      if (tmr_wr && off == 3'd3) cmp[15:8] <= cpu_out;
      if (tmr_wr && off == 3'd4) en <= cpu_out[7];

      if (tick && !cnt_wr && cnt_inc == cmp)
        match <= 1'b1;
      else if (tmr_wr && off == 3'd4 && cpu_out[0])
        match <= 1'b0;
    end
  end
`endif

  always_comb begin
    cpu_in = 8'hFF;
    case (sel)
      R_RAM:   cpu_in = ram_i;
      R_VID:   cpu_in = vid_i;
      R_ROM:   cpu_in = rom_i;
`ifdef CORE_BUS_TIMER_EN
      R_TMR:   cpu_in = tmr_q;
`endif
      default: cpu_in = 8'hFF;
    endcase
  end

endmodule
